// File: rtl/fifo_uart_tx.sv
// Drains a dual-clock FIFO on its read clock and serialises each byte as a UART 8N1 frame.
// All outputs are decoded from registered state, so they change only on clock edges or reset.
//
// state | meaning
// IDLE  | line high; waits for enable with a non-empty FIFO
// FETCH | pop strobe to the FIFO
// LATCH | FIFO read data captured into the shift register
// START | start bit (line low)
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (line high); done pulse in its last cycle
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  i_enable,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_rd_en,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LATCH = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;

  logic bit_end;
  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (i_enable && !i_fifo_empty) state_d = FETCH;
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        shift_d = i_rd_data;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data bits are selected by index rather than shifted, so the captured byte stays intact.
  assign o_rd_en   = (state_q == FETCH);
  assign o_busy    = (state_q != IDLE);
  assign o_tx_done = (state_q == STOP) && bit_end;
  assign o_tx      = (state_q == START) ? 1'b0 :
                     (state_q == DATA)  ? shift_q[idx_q] : 1'b1;

endmodule
